lcd_bus_responder: RTL and testbench



---
 rtl/lcd_bus_responder_if.sv | 11 +
 rtl/lcd_bus_responder.sv | 157 +++++++++++++++
 tb/tb_lcd_bus_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_responder_if.sv
// lcd_bus_responder_if: character-LCD write bus between a display controller and a responder
interface lcd_bus_responder_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [7:0] bus_rd_data;

    modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data, input bus_rd_data);
    modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_data, output bus_rd_data);
endinterface

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style bus decoder mirroring a 2x16 DDRAM, address counter and status
module lcd_bus_responder #(
    parameter int         BUSY_CYCLES = 4,
    parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
    input  logic                clk,
    input  logic                rst,
    lcd_bus_responder_if.slave  bus,
    input  logic [4:0]          i_char_rd_addr,
    output logic [7:0]          o_char_rd_data,
    output logic [6:0]          o_ac,
    output logic                o_disp_on,
    output logic                o_busy,
    output logic                o_cmd_strobe,
    output logic                o_proto_err
);
    localparam int CW = $clog2(BUSY_CYCLES + 32) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_HOLD} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_e_q;
    logic [1:0]      r_rs_q, r_rw_q;
    logic [7:0]      r_data_q1, r_data_q2;
    logic            r_tx_rs, r_tx_rw;
    logic [7:0]      r_tx_data;
    logic [CW-1:0]   r_cnt;
    logic [6:0]      r_ac;
    logic            r_id, r_disp_on, r_strobe, r_perr;
    logic [7:0]      r_bus_rd, r_char_rd;
    logic [7:0]      r_ddram [32];
    logic            w_fall, w_status, w_bad_addr, w_null, w_accept, w_reject, w_clear_cmd;
    logic [4:0]      w_idx;

    // AC moves through 0x00-0x0F and 0x40-0x4F as one 32-cell ring
    function automatic logic [6:0] f_step(input logic [6:0] ac, input logic id);
        if (id)
            return ac == 7'h0F ? 7'h40 : ac == 7'h4F ? 7'h00 : ac + 7'd1;
        return ac == 7'h00 ? 7'h4F : ac == 7'h40 ? 7'h0F : ac - 7'd1;
    endfunction

    assign w_fall      = r_e_q[2] & ~r_e_q[1];
    assign w_status    = r_rw_q[1] & ~r_rs_q[1];
    assign w_bad_addr  = ~r_rs_q[1] & ~r_rw_q[1] & r_data_q2[7] & (r_data_q2[5:4] != 2'b00);
    assign w_null      = ~r_rs_q[1] & ~r_rw_q[1] & (r_data_q2 == 8'h00);
    assign w_accept    = w_fall & ~w_status & (r_state == S_IDLE) & ~w_bad_addr & ~w_null;
    assign w_reject    = w_fall & ~w_status & ~w_accept;
    assign w_clear_cmd = ~r_tx_rs & ~r_tx_rw & (r_tx_data == 8'h01);
    assign w_idx       = {r_ac[6], r_ac[3:0]};

    assign o_busy          = r_state != S_IDLE;
    assign o_ac            = r_ac;
    assign o_disp_on       = r_disp_on;
    assign o_cmd_strobe    = r_strobe;
    assign o_proto_err     = r_perr;
    assign o_char_rd_data  = r_char_rd;
    assign bus.bus_rd_data = r_bus_rd;

    // Two-flop synchroniser on the asynchronous bus, plus a third E flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_q     <= '0;
            r_rs_q    <= '0;
            r_rw_q    <= '0;
            r_data_q1 <= '0;
            r_data_q2 <= '0;
        end else begin
            r_e_q     <= {r_e_q[1:0], bus.lcd_e};
            r_rs_q    <= {r_rs_q[0], bus.lcd_rs};
            r_rw_q    <= {r_rw_q[0], bus.lcd_rw};
            r_data_q1 <= bus.lcd_data;
            r_data_q2 <= r_data_q1;
        end
    end

    // State register and phase counter, which restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
        end
    end

    // Next state: accept in IDLE, one EXEC cycle, optional 32-cycle CLEAR, then the busy hold
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = w_clear_cmd ? S_CLEAR : S_HOLD;
            S_CLEAR: w_next = (r_cnt == CW'(31)) ? S_HOLD : S_CLEAR;
            S_HOLD:  w_next = (r_cnt == CW'(BUSY_CYCLES - 1)) ? S_IDLE : S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    // Transaction capture, pulses, status latch and instruction execution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_rs   <= 1'b0;
            r_tx_rw   <= 1'b0;
            r_tx_data <= '0;
            r_ac      <= '0;
            r_id      <= 1'b1;
            r_disp_on <= 1'b0;
            r_strobe  <= 1'b0;
            r_perr    <= 1'b0;
            r_bus_rd  <= '0;
        end else begin
            r_strobe <= w_accept | (w_fall & w_status);
            r_perr   <= w_reject;
            if (w_accept) begin
                r_tx_rs   <= r_rs_q[1];
                r_tx_rw   <= r_rw_q[1];
                r_tx_data <= r_data_q2;
            end
            if (r_state == S_EXEC) begin
                if (r_tx_rs) begin
                    if (r_tx_rw)
                        r_bus_rd <= r_ddram[w_idx];
                    r_ac <= f_step(r_ac, r_id);
                end else begin
                    casez (r_tx_data)
                        8'b1???????: r_ac <= r_tx_data[6:0];
                        8'b00001???: r_disp_on <= r_tx_data[2];
                        8'b000001??: r_id <= r_tx_data[1];
                        8'b0000001?: r_ac <= '0;
                        8'b00000001: begin
                            r_ac <= '0;
                            r_id <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (w_fall & w_status)
                r_bus_rd <= {o_busy, r_ac};
        end
    end

    // DDRAM shadow: data writes in EXEC, sequential fill in CLEAR, registered read port (old data on collision)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_ddram[i] <= CLEAR_FILL;
            r_char_rd <= '0;
        end else begin
            r_char_rd <= r_ddram[i_char_rd_addr];
            if (r_state == S_EXEC && r_tx_rs && !r_tx_rw)
                r_ddram[w_idx] <= r_tx_data;
            if (r_state == S_CLEAR)
                r_ddram[r_cnt[4:0]] <= CLEAR_FILL;
        end
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: randomized bus traffic checked against a linear-position display model
module tb_lcd_bus_responder;
    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       disp_on, busy, strobe, perr;

    always #5 clk = ~clk;

    lcd_bus_responder_if lcd ();

    lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_FILL(8'h20)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (lcd),
        .i_char_rd_addr (rd_addr),
        .o_char_rd_data (rd_data),
        .o_ac           (ac),
        .o_disp_on      (disp_on),
        .o_busy         (busy),
        .o_cmd_strobe   (strobe),
        .o_proto_err    (perr)
    );

    int n_vec = 0, n_err = 0;
    int n_strb = 0, n_perr = 0;

    // Pulses last one cycle, so each is seen on exactly one falling edge
    always @(negedge clk) begin
        if (strobe) n_strb++;
        if (perr) n_perr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: the cursor is a position 0..31 on a ring; line 2 starts at position 16
    logic [7:0] m_ram [32];
    int         m_pos;
    bit         m_id, m_disp;

    function automatic logic [6:0] m_ac();
        return 7'(m_pos < 16 ? m_pos : m_pos + 48);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_pos = 0; m_id = 1; m_disp = 0;
    endtask

    task automatic m_step();
        m_pos = (m_pos + (m_id ? 1 : 31)) % 32;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit rs, input bit rw, input logic [7:0] d, input int w);
        @(negedge clk);
        lcd.lcd_rs = rs; lcd.lcd_rw = rw; lcd.lcd_data = d; lcd.lcd_e = 1'b1;
        repeat (w) @(negedge clk);
        lcd.lcd_e = 1'b0;
    endtask

    task automatic read_cell(input int i, output logic [7:0] v);
        @(negedge clk); rd_addr = 5'(i);
        @(negedge clk); v = rd_data;
    endtask

    task automatic chk_cells();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            chk("cell", v, m_ram[i]);
        end
    endtask

    // One transaction from idle: predict from the model, drive it, let it finish, compare
    task automatic txn(input bit rs, input bit rw, input logic [7:0] d);
        int s0, p0, a, es, ep;
        bit rdc;
        logic [7:0] erd;
        s0 = n_strb; p0 = n_perr; es = 1; ep = 0; rdc = 0; erd = 0;
        if (rw && !rs) begin rdc = 1; erd = {1'b0, m_ac()}; end
        else if (rw) begin rdc = 1; erd = m_ram[m_pos]; m_step(); end
        else if (rs) begin m_ram[m_pos] = d; m_step(); end
        else if (d == 0) begin es = 0; ep = 1; end
        else if (d >= 128) begin
            a = d - 128;
            if (a < 16) m_pos = a;
            else if (a >= 64 && a < 80) m_pos = a - 48;
            else begin es = 0; ep = 1; end
        end
        else if (d >= 16) ;
        else if (d >= 8) m_disp = d[2];
        else if (d >= 4) m_id = d[1];
        else if (d >= 2) m_pos = 0;
        else begin m_pos = 0; m_id = 1; for (int i = 0; i < 32; i++) m_ram[i] = 8'h20; end
        pulse(rs, rw, d, 3);
        idle(60);
        chk("strobe", n_strb - s0, es);
        chk("perr", n_perr - p0, ep);
        chk("ac", ac, m_ac());
        chk("disp", disp_on, m_disp);
        chk("busy", busy, 0);
        if (rdc) chk("bus_rd", lcd.bus_rd_data, erd);
    endtask

    initial begin
        #500_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int s0, p0, t, cnt, kind;
        logic [7:0] v, d;
        lcd.lcd_e = 0; lcd.lcd_rs = 0; lcd.lcd_rw = 0; lcd.lcd_data = 0; rd_addr = 0;
        m_reset();
        idle(3);
        chk("rst_ac", ac, 0);
        chk("rst_disp", disp_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_perr", perr, 0);
        chk("rst_char_rd", rd_data, 0);
        chk("rst_bus_rd", lcd.bus_rd_data, 0);
        rst = 1'b0;
        idle(2);

        txn(0, 0, 8'h38); txn(0, 0, 8'h0C); txn(0, 0, 8'h06);
        s0 = n_strb;
        pulse(0, 0, 8'h01, 3);
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        chk("clear_busy_rise", busy, 1);
        cnt = 0;
        while (busy && cnt < 100) begin @(negedge clk); cnt++; end
        chk("clear_busy_len", cnt, 1 + 32 + BC);
        chk("clear_strobe", n_strb - s0, 1);
        m_pos = 0; m_id = 1;
        idle(5);
        chk("init_disp", disp_on, 1);
        chk("init_ac", ac, 0);
        chk_cells();

        txn(0, 0, 8'h8E); txn(1, 0, 8'h41); txn(1, 0, 8'h42); txn(1, 0, 8'h43);
        read_cell(14, v); chk("cell14", v, 8'h41);
        read_cell(15, v); chk("cell15", v, 8'h42);
        read_cell(16, v); chk("cell16", v, 8'h43);
        chk("ac_41", ac, 7'h41);

        txn(0, 0, 8'h04); txn(0, 0, 8'hC0); txn(1, 0, 8'h31); txn(1, 0, 8'h31);
        read_cell(16, v); chk("dec_cell16", v, 8'h31);
        read_cell(15, v); chk("dec_cell15", v, 8'h31);
        chk("ac_0e", ac, 7'h0E);
        txn(0, 0, 8'h06);

        s0 = n_strb; p0 = n_perr;
        m_ram[m_pos] = 8'h5A; m_step();
        pulse(1, 0, 8'h5A, 3);
        idle(1);
        pulse(1, 0, 8'hA5, 1);
        idle(60);
        chk("drop_strobe", n_strb - s0, 1);
        chk("drop_perr", n_perr - p0, 1);
        chk("drop_ac", ac, m_ac());
        chk_cells();

        s0 = n_strb; p0 = n_perr;
        pulse(0, 0, 8'h01, 3);
        idle(5);
        pulse(0, 1, 8'h00, 1);
        idle(60);
        m_pos = 0; m_id = 1;
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        chk("clr_status_busy", lcd.bus_rd_data[7], 1);
        chk("clr_status_ac", lcd.bus_rd_data[6:0], 0);
        chk("clr_status_strobe", n_strb - s0, 2);
        chk("clr_status_perr", n_perr - p0, 0);

        txn(0, 0, 8'h83);
        txn(0, 0, 8'h95);
        txn(0, 0, 8'h00);

        txn(0, 0, 8'h80); txn(1, 0, 8'h55);
        read_cell(0, v); chk("cell0_55", v, 8'h55);
        txn(0, 0, 8'h0C);
        pulse(0, 0, 8'h01, 3);
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_disp", disp_on, 0);
        chk("midrst_ac", ac, 0);
        rst = 1'b0;
        m_reset();
        read_cell(0, v); chk("midrst_cell0", v, 8'h20);
        chk_cells();

        repeat (50) begin
            kind = $urandom_range(0, 9);
            d = 8'($urandom);
            case (kind)
                0, 1, 2, 3: txn(1, 0, d);
                4:          txn(0, 0, {1'b1, d[0], 2'b00, d[4:1]});
                5:          txn(0, 0, {1'b1, d[6:0]});
                6:          txn(0, 0, {6'b000001, d[1:0]});
                7:          txn(0, 0, {5'b00001, d[2:0]});
                8:          txn(d[7], 1, d);
                default:    txn(0, 0, d[7:6] == 2'b00 ? 8'h01 : {1'b0, d[6:0]});
            endcase
        end
        chk_cells();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
